alsu_cmd_feeder: RTL and testbench

Command front-end sitting directly upstream of the ALSU. Accepts packed ALSU commands over a valid/ready handshake, buffers them in a small FIFO, and drives the ALSU input pins one command at a time with a configurable minimum spacing. It also produces an issue strobe so the downstream scoreboard knows which ALSU output cycles correspond to a real command.

---
 rtl/ALSU_pkg.sv | 46 ++++
 rtl/alsu_cmd_fifo.sv | 65 ++++++
 rtl/alsu_cmd_feeder.sv | 122 ++++++++++++
 tb/tb_alsu_cmd_feeder.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ALSU_pkg.sv
// ALSU_pkg: shared types for the ALSU command path.
//   opcode_e       ALSU opcode encoding (6 and 7 are not valid operations)
//   alsu_cmd_t     16-bit packed command, MSB first:
//                  {A, B, opcode, cin, red_op_A, red_op_B, bypass_A, bypass_B,
//                   direction, serial_in}
//   is_invalid_cmd true for commands the feeder's optional filter discards
package ALSU_pkg;

    typedef enum logic [2:0] {
        OR        = 3'd0,
        XOR       = 3'd1,
        ADD       = 3'd2,
        MULT      = 3'd3,
        SHIFT     = 3'd4,
        ROTATE    = 3'd5,
        INVALID_6 = 3'd6,
        INVALID_7 = 3'd7
    } opcode_e;

    typedef struct packed {
        logic signed [2:0] A;
        logic signed [2:0] B;
        opcode_e           opcode;
        logic              cin;
        logic              red_op_A;
        logic              red_op_B;
        logic              bypass_A;
        logic              bypass_B;
        logic              direction;
        logic              serial_in;
    } alsu_cmd_t;

    localparam int ALSU_CMD_W = $bits(alsu_cmd_t);

    // Invalid: reserved opcode, or a reduction request on an opcode that has
    // no reduction form (only OR/XOR reduce).
    function automatic logic is_invalid_cmd(alsu_cmd_t cmd);
        logic bad_op;
        logic bad_red;
        bad_op  = (cmd.opcode == INVALID_6) || (cmd.opcode == INVALID_7);
        bad_red = (cmd.red_op_A || cmd.red_op_B) &&
                  !((cmd.opcode == OR) || (cmd.opcode == XOR));
        return bad_op || bad_red;
    endfunction

endpackage

// File: rtl/alsu_cmd_fifo.sv
// alsu_cmd_fifo: synchronous FIFO with occupancy counter.
//   clk, rst      clock, asynchronous active-high reset (empties the FIFO)
//   push, wdata   write request/data; ignored while full
//   pop, rdata    read request; rdata shows the head entry (valid when !empty)
//   full, empty   occupancy flags, derived from the registered count
//   count         exact occupancy, 0..DEPTH
// DEPTH must be a power of 2 (>= 2) so the pointers wrap by overflow.
module alsu_cmd_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign rdata   = mem[rd_ptr];

    // Storage needs no reset: contents are only visible through the pointers.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alsu_cmd_feeder.sv
// alsu_cmd_feeder: buffers packed ALSU commands and drives the ALSU pins one
// command at a time, with ISSUE_GAP idle cycles enforced after each issue.
//   clk, rst            clock, asynchronous active-high reset
//   cmd_valid/ready     upstream handshake (cmd_ready = !full)
//   cmd_data            packed alsu_cmd_t
//   issue_en            downstream permits an issue this cycle
//   A, B, opcode, cin, red_op_A, red_op_B, bypass_A, bypass_B, direction,
//   serial_in           registered ALSU pins, held between issues
//   issue_strobe        one-cycle pulse when newly issued pins first appear
//   fifo_count          FIFO occupancy
//   drop_cnt            filtered commands, saturating at 255
// Build option: define ALSU_CMD_FILTER_EN to drop invalid commands at pop
// time; without it every command is issued and drop_cnt is 0.
module alsu_cmd_feeder
    import ALSU_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int ISSUE_GAP = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [15:0]                cmd_data,
    input  logic                       issue_en,
    output logic signed [2:0]          A,
    output logic signed [2:0]          B,
    output opcode_e                    opcode,
    output logic                       cin,
    output logic                       red_op_A,
    output logic                       red_op_B,
    output logic                       bypass_A,
    output logic                       bypass_B,
    output logic                       direction,
    output logic                       serial_in,
    output logic                       issue_strobe,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count,
    output logic [7:0]                 drop_cnt
);

    localparam logic [3:0] GAP_LOAD = 4'(ISSUE_GAP);

    logic                  fifo_full;
    logic                  fifo_empty;
    logic [ALSU_CMD_W-1:0] fifo_rdata;
    alsu_cmd_t             head;
    alsu_cmd_t             pins_q;
    logic [3:0]            gap_cnt;
    logic                  pop_try;
    logic                  drop;
    logic                  issue;

    alsu_cmd_fifo #(
        .WIDTH (ALSU_CMD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cmd_valid),
        .wdata (cmd_data),
        .pop   (pop_try),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign cmd_ready = !fifo_full;
    assign head      = alsu_cmd_t'(fifo_rdata);

    // A pop always consumes the head; it becomes an issue unless filtered.
    assign pop_try = !fifo_empty && issue_en && (gap_cnt == 4'd0);

`ifdef ALSU_CMD_FILTER_EN
    logic [7:0] drop_cnt_q;

    assign drop     = pop_try && is_invalid_cmd(head);
    assign drop_cnt = drop_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt_q <= 8'd0;
        end else if (drop && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_q <= drop_cnt_q + 8'd1;
        end
    end
`else
    assign drop     = 1'b0;
    assign drop_cnt = 8'd0;
`endif

    assign issue = pop_try && !drop;

    // Dropped entries leave pins, strobe and gap timer untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pins_q       <= '0;
            issue_strobe <= 1'b0;
            gap_cnt      <= 4'd0;
        end else begin
            issue_strobe <= issue;
            if (issue) begin
                pins_q  <= head;
                gap_cnt <= GAP_LOAD;
            end else if (gap_cnt != 4'd0) begin
                gap_cnt <= gap_cnt - 4'd1;
            end
        end
    end

    assign A         = pins_q.A;
    assign B         = pins_q.B;
    assign opcode    = pins_q.opcode;
    assign cin       = pins_q.cin;
    assign red_op_A  = pins_q.red_op_A;
    assign red_op_B  = pins_q.red_op_B;
    assign bypass_A  = pins_q.bypass_A;
    assign bypass_B  = pins_q.bypass_B;
    assign direction = pins_q.direction;
    assign serial_in = pins_q.serial_in;

endmodule

// File: tb/tb_alsu_cmd_feeder.sv
// Testbench for alsu_cmd_feeder (DEPTH=8, ISSUE_GAP=3). Accepted commands are
// queued as expected issues; a negedge monitor pops and compares them when
// issue_strobe is seen and checks the pins hold otherwise.
module tb_alsu_cmd_feeder;
    import ALSU_pkg::*;

    localparam int DEPTH = 8;
    localparam int GAP   = 3;
    localparam int CW    = $clog2(DEPTH + 1);
`ifdef ALSU_CMD_FILTER_EN
    localparam bit FILTER_ON = 1'b1;
`else
    localparam bit FILTER_ON = 1'b0;
`endif

    logic            clk;
    logic            rst;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [15:0]     cmd_data;
    logic            issue_en;
    logic signed [2:0] A;
    logic signed [2:0] B;
    opcode_e         opcode;
    logic            cin, red_op_A, red_op_B, bypass_A, bypass_B, direction, serial_in;
    logic            issue_strobe;
    logic [CW-1:0]   fifo_count;
    logic [7:0]      drop_cnt;
    logic [15:0]     pins;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          exp_drop = 0;
    int          last_strobe = -100;
    logic [15:0] last_pins = '0;
    logic [15:0] exp_v;
    logic [15:0] sbq[$];
    int          strobe_cyc[$];

    alsu_cmd_feeder #(.DEPTH(DEPTH), .ISSUE_GAP(GAP)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_data(cmd_data), .issue_en(issue_en), .A(A), .B(B), .opcode(opcode),
        .cin(cin), .red_op_A(red_op_A), .red_op_B(red_op_B), .bypass_A(bypass_A),
        .bypass_B(bypass_B), .direction(direction), .serial_in(serial_in),
        .issue_strobe(issue_strobe), .fifo_count(fifo_count), .drop_cnt(drop_cnt)
    );

    assign pins = {A, B, opcode, cin, red_op_A, red_op_B, bypass_A, bypass_B, direction, serial_in};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "watchdog");
    end

    // Independent model of the filter rule on the raw 16-bit layout.
    function automatic bit tb_invalid(input logic [15:0] c);
        logic [2:0] op;
        op = c[9:7];
        if (op >= 3'd6) return 1'b1;
        if ((c[5] || c[4]) && (op > 3'd1)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [15:0] make_cmd();
        logic [2:0] op;
        logic [1:0] red;
        op  = 3'($urandom_range(0, 5));
        red = (op <= 3'd1) ? 2'($urandom_range(0, 3)) : 2'b00;
        return {3'($urandom), 3'($urandom), op, 1'($urandom), red, 4'($urandom)};
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            last_pins   = '0;
            last_strobe = -100;
        end else if (issue_strobe) begin
            n_checks++;
            if (sbq.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_strobe: issue_strobe=1 at cycle %0d, required 0 (nothing pending)", cyc);
            end else begin
                exp_v = sbq.pop_front();
                if (pins !== exp_v) begin
                    n_errors++;
                    $display("FAIL issue_pins: pins=%h, required %h (cycle %0d)", pins, exp_v, cyc);
                end
            end
            n_checks++;
            if (cyc - last_strobe < GAP + 1) begin
                n_errors++;
                $display("FAIL strobe_spacing: %0d cycles since last strobe, required >= %0d", cyc - last_strobe, GAP + 1);
            end
            last_pins   = pins;
            last_strobe = cyc;
            strobe_cyc.push_back(cyc);
        end else begin
            n_checks++;
            if (pins !== last_pins) begin
                n_errors++;
                $display("FAIL pins_hold: pins=%h without strobe, required %h (cycle %0d)", pins, last_pins, cyc);
            end
        end
    end

    // Called at a negedge; returns at the negedge after acceptance.
    task automatic push_cmd(input logic [15:0] c);
        int w;
        w = 0;
        cmd_valid = 1'b1;
        cmd_data  = c;
        while (!cmd_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!cmd_ready) begin
            n_checks++;
            n_errors++;
            $display("FAIL push_timeout: cmd_ready=0 for 100 cycles, required 1");
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        if (FILTER_ON && tb_invalid(c)) begin
            if (exp_drop < 255) exp_drop++;
        end else begin
            sbq.push_back(c);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int w;
        w = 0;
        while ((fifo_count != 0 || sbq.size() != 0) && w < 300) begin
            @(negedge clk);
            w++;
        end
        n_checks++;
        if (fifo_count != 0 || sbq.size() != 0) begin
            n_errors++;
            $display("FAIL drain_timeout: fifo_count=%0d pending=%0d, required 0 and 0", fifo_count, sbq.size());
        end
        repeat (GAP + 2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd_valid = 1'b0; cmd_data = '0; issue_en = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;
        #1;
        n_checks++; if (fifo_count !== '0)  begin n_errors++; $display("FAIL reset_count: got %0d, required 0", fifo_count); end
        n_checks++; if (cmd_ready !== 1'b1) begin n_errors++; $display("FAIL reset_ready: got %b, required 1", cmd_ready); end
        n_checks++; if (issue_strobe !== 1'b0) begin n_errors++; $display("FAIL reset_strobe: got %b, required 0", issue_strobe); end
        n_checks++; if (pins !== 16'h0)     begin n_errors++; $display("FAIL reset_pins: got %h, required 0000", pins); end
        n_checks++; if (drop_cnt !== 8'd0)  begin n_errors++; $display("FAIL reset_drop: got %0d, required 0", drop_cnt); end
        @(negedge clk);
    endtask

    task automatic test_single();
        issue_en = 1'b1;
        push_cmd(16'b011_110_010_1_0_0_0_0_0_0);   // ADD A=3 B=-2 cin=1
        n_checks++; if (issue_strobe !== 1'b0) begin n_errors++; $display("FAIL single_early: strobe=%b at accept+1, required 0", issue_strobe); end
        n_checks++; if (fifo_count !== CW'(1)) begin n_errors++; $display("FAIL single_count: got %0d, required 1", fifo_count); end
        @(negedge clk);
        n_checks++; if (issue_strobe !== 1'b1) begin n_errors++; $display("FAIL single_strobe: strobe=%b at accept+2, required 1", issue_strobe); end
        n_checks++; if (A !== 3'sd3 || B !== -3'sd2 || opcode !== ADD || cin !== 1'b1) begin
            n_errors++; $display("FAIL single_pins: A=%0d B=%0d op=%0d cin=%b, required 3 -2 2 1", A, B, opcode, cin);
        end
        @(negedge clk);
        n_checks++; if (issue_strobe !== 1'b0) begin n_errors++; $display("FAIL single_pulse: strobe=%b at accept+3, required 0", issue_strobe); end
        wait_drain();
    endtask

    task automatic test_full();
        issue_en = 1'b0;
        for (int i = 0; i < DEPTH; i++) push_cmd(make_cmd());
        n_checks++; if (fifo_count !== CW'(DEPTH)) begin n_errors++; $display("FAIL full_count: got %0d, required %0d", fifo_count, DEPTH); end
        n_checks++; if (cmd_ready !== 1'b0) begin n_errors++; $display("FAIL full_ready: got %b, required 0", cmd_ready); end
        // Offer a command in the first pop cycle: it must not be accepted.
        cmd_valid = 1'b1;
        cmd_data  = make_cmd();
        issue_en  = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        n_checks++; if (fifo_count !== CW'(DEPTH - 1)) begin n_errors++; $display("FAIL full_pop_count: got %0d, required %0d", fifo_count, DEPTH - 1); end
        n_checks++; if (cmd_ready !== 1'b1) begin n_errors++; $display("FAIL full_ready_back: got %b, required 1", cmd_ready); end
        wait_drain();
    endtask

    task automatic test_throughput();
        issue_en = 1'b0;
        for (int i = 0; i < 4; i++) push_cmd(make_cmd());
        strobe_cyc.delete();
        issue_en = 1'b1;
        wait_drain();
        n_checks++; if (strobe_cyc.size() != 4) begin n_errors++; $display("FAIL gap_strobes: got %0d strobes, required 4", strobe_cyc.size()); end
        for (int i = 1; i < strobe_cyc.size(); i++) begin
            n_checks++;
            if (strobe_cyc[i] - strobe_cyc[i-1] != GAP + 1) begin
                n_errors++; $display("FAIL gap_period: strobe interval %0d, required %0d", strobe_cyc[i] - strobe_cyc[i-1], GAP + 1);
            end
        end
    endtask

    task automatic test_filter();
        issue_en = 1'b0;
        strobe_cyc.delete();
        push_cmd({3'd1, 3'd2, 3'd0, 1'b0, 2'b00, 4'b0000});   // OR
        push_cmd({3'd1, 3'd2, 3'd6, 1'b0, 2'b00, 4'b0000});   // opcode 6
        push_cmd({3'd1, 3'd2, 3'd2, 1'b0, 2'b10, 4'b0000});   // ADD with red_op_A
        push_cmd({3'd2, 3'd3, 3'd3, 1'b0, 2'b00, 4'b0000});   // MULT
        issue_en = 1'b1;
        wait_drain();
        n_checks++; if (strobe_cyc.size() != (FILTER_ON ? 2 : 4)) begin
            n_errors++; $display("FAIL filter_strobes: got %0d, required %0d", strobe_cyc.size(), FILTER_ON ? 2 : 4);
        end
        n_checks++; if (drop_cnt !== 8'(exp_drop)) begin n_errors++; $display("FAIL filter_drop_cnt: got %0d, required %0d", drop_cnt, exp_drop); end
    endtask

    task automatic test_reset_mid();
        int w;
        issue_en = 1'b0;
        for (int i = 0; i < 6; i++) push_cmd(make_cmd());
        issue_en = 1'b1;
        w = 0;
        while (!issue_strobe && w < 20) begin @(negedge clk); w++; end
        n_checks++; if (issue_strobe !== 1'b1) begin n_errors++; $display("FAIL rstmid_first: strobe=%b, required 1", issue_strobe); end
        #1 rst = 1'b1;
        #1;
        n_checks++; if (fifo_count !== '0) begin n_errors++; $display("FAIL rstmid_count: got %0d, required 0", fifo_count); end
        n_checks++; if (pins !== 16'h0)    begin n_errors++; $display("FAIL rstmid_pins: got %h, required 0000", pins); end
        n_checks++; if (issue_strobe !== 1'b0) begin n_errors++; $display("FAIL rstmid_strobe: got %b, required 0", issue_strobe); end
        n_checks++; if (drop_cnt !== 8'd0) begin n_errors++; $display("FAIL rstmid_drop: got %0d, required 0", drop_cnt); end
        sbq.delete();
        exp_drop = 0;
        @(negedge clk);
        #1 rst = 1'b0;
        repeat (10) @(negedge clk);
        n_checks++; if (fifo_count !== '0 || cmd_ready !== 1'b1) begin
            n_errors++; $display("FAIL rstmid_after: count=%0d ready=%b, required 0 1", fifo_count, cmd_ready);
        end
        // Gap timer was cleared too: a new command issues at accept+2.
        push_cmd(16'b001_111_000_0_0_0_1_0_1_0);
        @(negedge clk);
        n_checks++; if (issue_strobe !== 1'b1) begin n_errors++; $display("FAIL rstmid_reissue: strobe=%b at accept+2, required 1", issue_strobe); end
        wait_drain();
    endtask

    task automatic test_wrap();
        logic [15:0] c;
        issue_en = 1'b0;
        strobe_cyc.delete();
        for (int i = 0; i < 4; i++) push_cmd(make_cmd());
        for (int k = 0; k < 16; k++) begin
            n_checks++; if (fifo_count !== CW'(4)) begin n_errors++; $display("FAIL wrap_pre_count: got %0d, required 4 (iter %0d)", fifo_count, k); end
            c = make_cmd();
            cmd_valid = 1'b1;
            cmd_data  = c;
            issue_en  = 1'b1;
            @(posedge clk);
            sbq.push_back(c);
            @(negedge clk);
            cmd_valid = 1'b0;
            n_checks++; if (fifo_count !== CW'(4) || issue_strobe !== 1'b1) begin
                n_errors++; $display("FAIL wrap_pushpop: count=%0d strobe=%b, required 4 1 (iter %0d)", fifo_count, issue_strobe, k);
            end
            repeat (GAP) @(negedge clk);
        end
        wait_drain();
        n_checks++; if (strobe_cyc.size() != 20) begin n_errors++; $display("FAIL wrap_total: got %0d issues, required 20", strobe_cyc.size()); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_full();
        test_throughput();
        test_filter();
        test_reset_mid();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
